toggle_pulse_gen: RTL and testbench

- Upstream stage for the T flip-flop: conditions a noisy, asynchronous push-button or switch input into clean single-cycle toggle pulses on `t`.
- The pulse drives the flip-flop's `t` input, so each debounced press toggles `q` exactly once.
- Also exports the debounced level and a running press count for status/LED use.

---
 rtl/toggle_pulse_gen.sv | 96 +++++++++
 tb/tb_toggle_pulse_gen.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/toggle_pulse_gen.sv
// Debounces an asynchronous button into a clean level, a one-cycle toggle pulse
// on each accepted press, and a running press count.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   IDLE_LOW  | debounced level is 0, waiting for s to rise
//   WAIT_HIGH | s is 1, counting stable cycles before accepting a press
//   HIGH      | debounced level is 1, waiting for s to fall
//   WAIT_LOW  | s is 0, counting stable cycles before accepting a release
module toggle_pulse_gen #(
   parameter int DEBOUNCE = 1000,
   parameter int CNT_W    = 16,
   parameter int PCNT_W   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_in,
   output logic              t,
   output logic              btn_level,
   output logic [PCNT_W-1:0] press_cnt
);

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      HIGH      = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             sync_meta;
   logic             s;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_meta <= 1'b0;
         s         <= 1'b0;
         state     <= IDLE_LOW;
         cnt       <= '0;
         t         <= 1'b0;
         btn_level <= 1'b0;
         press_cnt <= '0;
      end else begin
         sync_meta <= btn_in;
         s         <= sync_meta;
         t         <= 1'b0;
         case (state)
            IDLE_LOW: begin
               if (s) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= HIGH;
                  t         <= 1'b1;
                  btn_level <= 1'b1;
                  press_cnt <= press_cnt + 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HIGH: begin
               if (!s) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
               end
            end
            WAIT_LOW: begin
               // a release bounce returns to HIGH without touching btn_level
               if (s) begin
                  state <= HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state     <= IDLE_LOW;
                  btn_level <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_toggle_pulse_gen.sv
// Directed bench for toggle_pulse_gen with DEBOUNCE=4, PCNT_W=8; a local T
// flip-flop model consumes t to show toggling.
module tb_toggle_pulse_gen;

   logic       clk;
   logic       rst_n;
   logic       btn_in;
   logic       t;
   logic       btn_level;
   logic [7:0] press_cnt;

   logic       q;
   int         pulse_cnt;
   int         vectors;
   int         miscompares;
   int         p0;

   toggle_pulse_gen #(
      .DEBOUNCE(4),
      .CNT_W   (16),
      .PCNT_W  (8)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn_in   (btn_in),
      .t        (t),
      .btn_level(btn_level),
      .press_cnt(press_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) q <= 1'b0;
      else if (t) q <= ~q;
   end

   initial pulse_cnt = 0;
   always @(posedge clk) if (t === 1'b1) pulse_cnt = pulse_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      btn_in = 1'b0;
      rst_n  = 1'b0;
      @(negedge clk);
      rst_n  = 1'b1;
   endtask

   task automatic press();
      @(negedge clk);
      btn_in = 1'b1;
      repeat (12) @(negedge clk);
      btn_in = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst_n       = 1'b0;
      btn_in      = 1'b0;

      // reset state
      @(negedge clk);
      chk("reset_t", 32'(t), 32'd0);
      chk("reset_level", 32'(btn_level), 32'd0);
      chk("reset_cnt", 32'(press_cnt), 32'd0);
      rst_n = 1'b1;

      // bounce rejection: high 3, low 3, high 2, then low
      p0 = pulse_cnt;
      btn_in = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (k == 2) btn_in = 1'b0;
         if (k == 5) btn_in = 1'b1;
         if (k == 7) btn_in = 1'b0;
         chk("bounce_level", 32'(btn_level), 32'd0);
      end
      chk("bounce_pulses", 32'(pulse_cnt - p0), 32'd0);
      chk("bounce_cnt", 32'(press_cnt), 32'd0);

      // clean press: pulse and level change after edge 7
      p0 = pulse_cnt;
      btn_in = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         chk($sformatf("press_t_e%0d", k), 32'(t), (k == 7) ? 32'd1 : 32'd0);
         chk($sformatf("press_level_e%0d", k), 32'(btn_level), (k >= 7) ? 32'd1 : 32'd0);
      end
      chk("press_pulses", 32'(pulse_cnt - p0), 32'd1);
      chk("press_cnt1", 32'(press_cnt), 32'd1);

      // release bounce: low for 2 cycles then high again
      btn_in = 1'b0;
      repeat (2) @(negedge clk);
      btn_in = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("relbounce_level", 32'(btn_level), 32'd1);
      end
      chk("relbounce_pulses", 32'(pulse_cnt - p0), 32'd1);

      // final release: level falls after edge 7
      btn_in = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("release_level_e%0d", k), 32'(btn_level), (k >= 7) ? 32'd0 : 32'd1);
      end
      chk("release_cnt", 32'(press_cnt), 32'd1);

      // three presses drive the T flip-flop 0->1->0->1
      do_reset();
      chk("chain_q0", 32'(q), 32'd0);
      press();
      chk("chain_q1", 32'(q), 32'd1);
      press();
      chk("chain_q2", 32'(q), 32'd0);
      press();
      chk("chain_q3", 32'(q), 32'd1);
      chk("chain_cnt", 32'(press_cnt), 32'd3);

      // reset asserted mid-debounce, between clock edges
      @(negedge clk);
      btn_in = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_t", 32'(t), 32'd0);
      chk("midrst_level", 32'(btn_level), 32'd0);
      chk("midrst_cnt", 32'(press_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      p0 = pulse_cnt;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         chk($sformatf("midrst_t_e%0d", k), 32'(t), (k == 7) ? 32'd1 : 32'd0);
      end
      chk("midrst_pulses", 32'(pulse_cnt - p0), 32'd1);
      chk("midrst_cnt1", 32'(press_cnt), 32'd1);
      btn_in = 1'b0;
      repeat (12) @(negedge clk);

      // press counter wraps after 256 presses
      do_reset();
      p0 = pulse_cnt;
      for (int n = 0; n < 255; n++) press();
      chk("wrap_cnt255", 32'(press_cnt), 32'd255);
      press();
      chk("wrap_cnt0", 32'(press_cnt), 32'd0);
      chk("wrap_pulses", 32'(pulse_cnt - p0), 32'd256);
      chk("wrap_level", 32'(btn_level), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
